// File: rtl/status_led_ctrl.sv
// Board status-LED driver: CPU lifecycle on RGB2, execution mode on RGB1, PWM dimming on all channels.
// Optional RUNNING heartbeat blink is compiled in when LED_BLINK_EN is defined.
module status_led_ctrl #(
   parameter int unsigned PWM_W   = 8,
   parameter int unsigned BLINK_W = 24
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_instr_transmit_done,
   input  logic             i_start_cpu,
   input  logic             i_halt,
   input  logic             i_clear,
   input  logic             i_step_execution,
   input  logic [PWM_W-1:0] i_brightness,
   output logic [1:0]       o_state,
   output logic             RGB1_RED,
   output logic             RGB1_BLUE,
   output logic             RGB2_RED,
   output logic             RGB2_GREEN,
   output logic             RGB2_BLUE
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOADED  = 2'd1,
      ST_RUNNING = 2'd2,
      ST_HALTED  = 2'd3
   } state_t;

   state_t             state_r;
   state_t             state_next_s;
   logic [PWM_W-1:0]   pwm_cnt_r;
   logic [PWM_W-1:0]   bright_r;
   logic [PWM_W-1:0]   duty_s;
   logic               pwm_on_s;
   logic               blink_gate_s;
   logic [2:0]         rgb2_dec_s;
   logic [1:0]         rgb1_dec_s;
   logic [2:0]         rgb2_r;
   logic [1:0]         rgb1_r;

   // Lifecycle state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic; clear overrides every other request
   always_comb begin
      state_next_s = state_r;
      if (i_clear) begin
         state_next_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (i_instr_transmit_done) state_next_s = ST_LOADED;
               else                       state_next_s = ST_IDLE;
            end
            ST_LOADED: begin
               if (i_start_cpu) state_next_s = ST_RUNNING;
               else             state_next_s = ST_LOADED;
            end
            ST_RUNNING: begin
               if (i_halt) state_next_s = ST_HALTED;
               else        state_next_s = ST_RUNNING;
            end
            ST_HALTED: state_next_s = ST_HALTED;
            default:   state_next_s = ST_IDLE;
         endcase
      end
   end

   // Free-running PWM counter and period-aligned brightness latch
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pwm_cnt_r <= {PWM_W{1'b0}};
         bright_r  <= {PWM_W{1'b0}};
      end else begin
         pwm_cnt_r <= pwm_cnt_r + PWM_W'(1);
         if (pwm_cnt_r == {PWM_W{1'b0}}) begin
            bright_r <= i_brightness;
         end
      end
   end

   // The value captured at cnt==0 already governs that first slot of the period
   assign duty_s   = (pwm_cnt_r == {PWM_W{1'b0}}) ? i_brightness : bright_r;
   assign pwm_on_s = (pwm_cnt_r < duty_s) | (duty_s == {PWM_W{1'b1}});

`ifdef LED_BLINK_EN
   logic [BLINK_W-1:0] blink_cnt_r;
   logic               blink_phase_r;
   logic               run_entry_s;

   assign run_entry_s = (state_next_s == ST_RUNNING) && (state_r != ST_RUNNING);

   // Heartbeat divider, restarted dark on every entry to RUNNING
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         blink_cnt_r   <= {BLINK_W{1'b0}};
         blink_phase_r <= 1'b0;
      end else if (run_entry_s) begin
         blink_cnt_r   <= {BLINK_W{1'b0}};
         blink_phase_r <= 1'b0;
      end else begin
         blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
         if (blink_cnt_r == {BLINK_W{1'b1}}) begin
            blink_phase_r <= ~blink_phase_r;
         end
      end
   end

   assign blink_gate_s = blink_phase_r;
`else
   assign blink_gate_s = (BLINK_W != 32'd0);
`endif

   // Colour decode: one colour per LED at most
   always_comb begin
      rgb2_dec_s = 3'b000;
      case (state_r)
         ST_IDLE:    rgb2_dec_s = 3'b000;
         ST_LOADED:  rgb2_dec_s = 3'b010;
         ST_RUNNING: rgb2_dec_s = {2'b00, blink_gate_s};
         ST_HALTED:  rgb2_dec_s = 3'b100;
         default:    rgb2_dec_s = 3'b000;
      endcase
      if (i_step_execution) begin
         rgb1_dec_s = 2'b10;
      end else begin
         rgb1_dec_s = 2'b01;
      end
   end

   // Registered, PWM-gated LED drivers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rgb2_r <= 3'b000;
         rgb1_r <= 2'b00;
      end else begin
         rgb2_r <= rgb2_dec_s & {3{pwm_on_s}};
         rgb1_r <= rgb1_dec_s & {2{pwm_on_s}};
      end
   end

   assign o_state                          = state_r;
   assign {RGB2_RED, RGB2_GREEN, RGB2_BLUE} = rgb2_r;
   assign {RGB1_RED, RGB1_BLUE}             = rgb1_r;

endmodule

// File: tb/tb_status_led_ctrl.sv
// Directed self-checking bench for status_led_ctrl (default or LED_BLINK_EN build, BLINK_W=4).
module tb_status_led_ctrl;

   logic       clk;
   logic       rst_n;
   logic       done, start, halt, clr, step_exec;
   logic [7:0] bright;
   logic [1:0] state;
   logic       rgb1_r, rgb1_b, rgb2_r, rgb2_g, rgb2_b;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   localparam logic [3:0] P_DONE  = 4'b1000;
   localparam logic [3:0] P_START = 4'b0100;
   localparam logic [3:0] P_HALT  = 4'b0010;
   localparam logic [3:0] P_CLR   = 4'b0001;

`ifdef LED_BLINK_EN
   localparam int RUN_BLUE_FIRST = 0;
   localparam int RUN_HI_FIRST16 = 0;
`else
   localparam int RUN_BLUE_FIRST = 1;
   localparam int RUN_HI_FIRST16 = 16;
`endif

   status_led_ctrl #(.PWM_W(8), .BLINK_W(4)) dut (
      .i_clk                 (clk),
      .i_rst_n               (rst_n),
      .i_instr_transmit_done (done),
      .i_start_cpu           (start),
      .i_halt                (halt),
      .i_clear               (clr),
      .i_step_execution      (step_exec),
      .i_brightness          (bright),
      .o_state               (state),
      .RGB1_RED              (rgb1_r),
      .RGB1_BLUE             (rgb1_b),
      .RGB2_RED              (rgb2_r),
      .RGB2_GREEN            (rgb2_g),
      .RGB2_BLUE             (rgb2_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic pulse(input logic [3:0] v);
      {done, start, halt, clr} = v;
      step(1);
      {done, start, halt, clr} = 4'b0000;
   endtask

   initial begin
      int   hi, other;
      logic prev;
      bit   found;

      rst_n = 1'b0; bright = 8'hFF; step_exec = 1'b0;
      {done, start, halt, clr} = 4'b0000;
      #22;
      check("rst_state", state, 2'd0);
      check("rst_rgb2", {rgb2_r, rgb2_g, rgb2_b}, 3'b000);
      check("rst_rgb1", {rgb1_r, rgb1_b}, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;
      step(3);
      check("rgb1_idle_blue", {rgb1_r, rgb1_b}, 2'b01);
      check("idle_rgb2_off", {rgb2_r, rgb2_g, rgb2_b}, 3'b000);

      // Lifecycle walk: o_state immediate, LED one cycle later
      pulse(P_DONE);
      check("st_loaded", state, 2'd1);
      check("led_lag_idle", {rgb2_r, rgb2_g, rgb2_b}, 3'b000);
      step(1);
      check("led_green", {rgb2_r, rgb2_g, rgb2_b}, 3'b010);
      pulse(P_START);
      check("st_running", state, 2'd2);
      check("led_lag_green", {rgb2_r, rgb2_g, rgb2_b}, 3'b010);
      step(1);
      check("led_blue", {rgb2_r, rgb2_g, rgb2_b}, RUN_BLUE_FIRST);
      pulse(P_HALT);
      check("st_halted", state, 2'd3);
      step(1);
      check("led_red", {rgb2_r, rgb2_g, rgb2_b}, 3'b100);

      // Ignored requests and clear priority
      pulse(P_CLR);
      check("clr_from_halted", state, 2'd0);
      pulse(P_DONE);
      pulse(P_HALT);
      check("halt_in_loaded", state, 2'd1);
      pulse(P_START);
      pulse(P_HALT);
      pulse(P_START);
      check("start_in_halted", state, 2'd3);
      pulse(P_CLR);
      pulse(P_DONE);
      pulse(P_START);
      check("rerun", state, 2'd2);
      pulse(P_CLR | P_HALT);
      check("clr_beats_halt", state, 2'd0);
      step(1);
      check("clr_rgb2_off", {rgb2_r, rgb2_g, rgb2_b}, 3'b000);

      // PWM duty and period-aligned brightness update
      bright = 8'h40;
      pulse(P_DONE);
      step(300);
      found = 1'b0;
      prev  = rgb2_g;
      for (int i = 0; i < 600 && !found; i++) begin
         step(1);
         if (!prev && rgb2_g) found = 1'b1;
         prev = rgb2_g;
      end
      check("pwm_sync", found, 1);
      hi = 1; other = 0;
      for (int i = 1; i < 256; i++) begin
         step(1);
         hi    += rgb2_g;
         other += (rgb2_r | rgb2_b);
      end
      check("duty_40", hi, 64);
      check("loaded_excl", other, 0);
      hi = 0;
      for (int i = 0; i < 101; i++) begin step(1); hi += rgb2_g; end
      check("duty_40_head", hi, 64);
      bright = 8'h80;
      hi = 0;
      for (int i = 0; i < 155; i++) begin step(1); hi += rgb2_g; end
      check("old_duty_holds", hi, 0);
      hi = 0;
      for (int i = 0; i < 256; i++) begin step(1); hi += rgb2_g; end
      check("duty_80", hi, 128);
      bright = 8'h00;
      step(256);
      hi = 0;
      for (int i = 0; i < 256; i++) begin step(1); hi += rgb2_g; end
      check("duty_00", hi, 0);

      // Mode LED
      bright = 8'hFF;
      step(256);
      check("rgb1_blue", {rgb1_r, rgb1_b}, 2'b01);
      step_exec = 1'b1;
      check("rgb1_hold", {rgb1_r, rgb1_b}, 2'b01);
      step(1);
      check("rgb1_red", {rgb1_r, rgb1_b}, 2'b10);
      step_exec = 1'b0;
      step(1);
      check("rgb1_back_blue", {rgb1_r, rgb1_b}, 2'b01);

      // RUNNING blue: steady, or 16 dark / 16 lit heartbeat
      pulse(P_START);
      check("run_state", state, 2'd2);
      hi = 0;
      for (int i = 0; i < 16; i++) begin step(1); hi += rgb2_b; end
      check("run_first16", hi, RUN_HI_FIRST16);
      hi = 0;
      for (int i = 0; i < 16; i++) begin step(1); hi += rgb2_b; end
      check("run_second16", hi, 16);

      // Asynchronous reset mid-RUNNING
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_state", state, 2'd0);
      check("arst_rgb2", {rgb2_r, rgb2_g, rgb2_b}, 3'b000);
      check("arst_rgb1", {rgb1_r, rgb1_b}, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;
      step(1);
      check("post_arst_state", state, 2'd0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
